// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready beat bus that links two pipeline stages. Each beat carries an
// opaque control bundle and a data payload.
//
//   valid  master -> slave  a beat is present on ctrl/data
//   ready  slave  -> master the slave takes the beat this cycle
//   ctrl   master -> slave  control bundle   [CTRL_W-1:0]
//   data   master -> slave  payload          [DATA_W-1:0]
//
// A beat transfers on any cycle where valid and ready are both high.
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 9
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input  ready);
   modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage register (ID/EX, EX/MEM, MEM/WB). It moves a control
// bundle plus payload from one stage to the next under valid/ready, with
// optional skid storage, a synchronous flush for squashing, and bubble
// injection. A slot that is not valid presents all-zero control, so it acts
// as a NOP downstream.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control bundle width
//   SKID    1: two entries (main + skid), in_ready depends only on flops
//           0: one entry, in_ready depends combinationally on out_ready
//
// Ports
//   Clk         rising-edge clock
//   Reset       asynchronous active-high reset
//   upstream    incoming beats (slave side: valid/ctrl/data in, ready out)
//   downstream  outgoing beats (master side: valid/ctrl/data out, ready in)
//   flush       squash every held beat at the next edge; blocks acceptance
//   bubble      block acceptance; held beats still drain
//   occupancy   number of held beats (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 9,
   parameter bit SKID   = 1'b1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   pipe_stage_reg_if.slave          upstream,
   pipe_stage_reg_if.master         downstream,
   input  logic                     flush,
   input  logic                     bubble,
   output logic [1:0]               occupancy
);

   // The state encoding is the beat count, so occupancy is the state itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state, state_nxt;

   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [DATA_W-1:0] main_data, skid_data;

   logic              main_valid;
   logic              in_ready;
   logic              accept;
   logic              drain;
   logic              load_main_in;
   logic              load_main_skid;
   logic              load_skid;

   assign main_valid = (state != ST_EMPTY);
   assign accept     = upstream.valid & in_ready;
   assign drain      = main_valid & downstream.ready;

   // With a skid entry, ready is a decode of state only (FULL == skid valid),
   // which breaks the combinational ready path through this stage.
   always_comb begin
      if (SKID)
         in_ready = (state != ST_FULL) & ~flush & ~bubble & ~Reset;
      else
         in_ready = (~main_valid | downstream.ready) & ~flush & ~bubble & ~Reset;
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      // Flush wins over a simultaneous drain; accept cannot coincide with it
      // because in_ready is low while flush is high.
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nxt    = ST_ONE;
                  load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && drain) begin
                  load_main_in = 1'b1;
               end else if (accept && SKID) begin
                  state_nxt = ST_FULL;
                  load_skid = 1'b1;
               end else if (drain) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (drain) begin
                  state_nxt      = ST_ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_EMPTY;
      else       state <= state_nxt;
   end

   // NOTE: the entry registers are reset because out_data must read zero
   // after reset; flush and drain deliberately leave them untouched.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else begin
         if (load_main_in) begin
            main_ctrl <= upstream.ctrl;
            main_data <= upstream.data;
         end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_ctrl <= upstream.ctrl;
            skid_data <= upstream.data;
         end
      end
   end

   assign upstream.ready   = in_ready;
   assign downstream.valid = main_valid;
   // Control is gated so an empty slot is a NOP; payload is left as-is.
   assign downstream.ctrl  = main_valid ? main_ctrl : '0;
   assign downstream.data  = main_data;
   assign occupancy        = state;

endmodule
